// File: rtl/fetch_redirect_unit_pkg.sv
// fetch_redirect_unit_pkg: training codes, FSM states and prediction-slot type shared
// with the predictor.
package fetch_redirect_unit_pkg;
    typedef enum logic [1:0] {
        BCOND_NONE      = 2'b00,
        BCOND_NOT_TAKEN = 2'b10,
        BCOND_TAKEN     = 2'b11
    } bcond_e;
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;
    typedef struct packed {
        logic        valid;
        logic [31:0] pred;
    } slot_t;
    localparam logic [31:0] INSN_BYTES = 32'd4;
endpackage

// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: pipeline-side inputs and fetch/training outputs of the
// redirect stage.
interface fetch_redirect_unit_if #(parameter int CNT_W = 32);
    logic [31:0]      pred_next_pc;
    logic             stall;
    logic             halt_req;
    logic             ex_valid;
    logic             ex_is_ctrl;
    logic             ex_taken;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic [31:0]      pc;
    logic [1:0]       bcond;
    logic [31:0]      ex_correct_next_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             halted;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output pred_next_pc, stall, halt_req, ex_valid, ex_is_ctrl, ex_taken, ex_pc, ex_target,
        input  pc, bcond, ex_correct_next_pc, flush_if_id, flush_id_ex, halted,
               branch_count, mispredict_count
    );
    modport slave (
        input  pred_next_pc, stall, halt_req, ex_valid, ex_is_ctrl, ex_taken, ex_pc, ex_target,
        output pc, bcond, ex_correct_next_pc, flush_if_id, flush_id_ex, halted,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/fetch_redirect_unit_pred_track_slot.sv
// pred_track_slot: one {valid, pred} tracking register; invalidate beats load beats hold.
module pred_track_slot
    import fetch_redirect_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inval_i,
    input  logic  load_i,
    input  slot_t d_i,
    output slot_t q_o
);
    slot_t slot_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) slot_q <= '0;
        else if (inval_i) slot_q.valid <= 1'b0;
        else if (load_i) slot_q <= d_i;

    assign q_o = slot_q;
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: owns the fetch PC, tracks predictions through IF/ID and ID/EX and
// redirects/trains when the EX outcome disagrees with the prediction.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
)(
    input logic                  clk,
    input logic                  rst_n,
    fetch_redirect_unit_if.slave fr_if
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [31:0]      pc_q, pc_d, correct_pc;
    logic [CNT_W-1:0] br_cnt_q, mp_cnt_q;
    slot_t            fetch_slot, if_slot, ex_slot;
    logic             run, mispredict, advance, bubble;
    bcond_e           bcond;

    assign run        = state_q == ST_RUN;
    assign correct_pc = (fr_if.ex_is_ctrl & fr_if.ex_taken) ? fr_if.ex_target : fr_if.ex_pc + INSN_BYTES;
    assign bcond      = (!run || !(fr_if.ex_valid & fr_if.ex_is_ctrl)) ? BCOND_NONE :
                        fr_if.ex_taken ? BCOND_TAKEN : BCOND_NOT_TAKEN;
    assign mispredict = run & fr_if.ex_valid & ex_slot.valid & (correct_pc != ex_slot.pred);
    // Redirect overrides halt and stall; halt overrides stall.
    assign advance    = run & ~mispredict & ~fr_if.halt_req & ~fr_if.stall;
    assign bubble     = run & ~mispredict & ~fr_if.halt_req & fr_if.stall;
    assign pc_d       = mispredict ? correct_pc : advance ? fr_if.pred_next_pc : pc_q;
    assign fetch_slot = {1'b1, fr_if.pred_next_pc};

    pred_track_slot u_if_slot (
        .clk(clk), .rst_n(rst_n), .inval_i(mispredict), .load_i(advance),
        .d_i(fetch_slot), .q_o(if_slot)
    );

    pred_track_slot u_ex_slot (
        .clk(clk), .rst_n(rst_n), .inval_i(mispredict | bubble), .load_i(advance),
        .d_i(if_slot), .q_o(ex_slot)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (run) begin
            pc_q <= pc_d;
            if (!mispredict && fr_if.halt_req) state_q <= ST_HALTED;
            if (bcond != BCOND_NONE && br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_ONE;
            if (mispredict && mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + CNT_ONE;
        end

    assign fr_if.pc                 = pc_q;
    assign fr_if.bcond              = bcond;
    assign fr_if.ex_correct_next_pc = correct_pc;
    assign fr_if.flush_if_id        = mispredict;
    assign fr_if.flush_id_ex        = mispredict;
    assign fr_if.halted             = state_q == ST_HALTED;
    assign fr_if.branch_count       = br_cnt_q;
    assign fr_if.mispredict_count   = mp_cnt_q;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed scenarios checked every cycle against an in-flight
// prediction model, plus literal expectations at the interesting points.
module tb_fetch_redirect_unit;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fetch_redirect_unit_if #(.CNT_W(CNT_W)) fr_if ();
    fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .fr_if(fr_if));

    // Model: fetch PC, the two in-flight predictions (0 = IF/ID, 1 = ID/EX), and raw event counts.
    logic [31:0] m_pc;
    logic        m_v [2];
    logic [31:0] m_p [2];
    logic        m_halt;
    int          m_bc, m_mc;

    function automatic logic [31:0] m_cnp();
        return (fr_if.ex_is_ctrl && fr_if.ex_taken) ? fr_if.ex_target : fr_if.ex_pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_bcond();
        if (m_halt || !(fr_if.ex_valid && fr_if.ex_is_ctrl)) return 32'd0;
        return fr_if.ex_taken ? 32'd3 : 32'd2;
    endfunction

    function automatic logic [31:0] m_mis();
        return {31'd0, !m_halt && fr_if.ex_valid && m_v[1] && (m_cnp() != m_p[1])};
    endfunction

    function automatic logic [31:0] sat(input int n);
        return 32'(n > SAT ? SAT : n);
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_pc <= 32'h0; m_v[0] <= 1'b0; m_v[1] <= 1'b0; m_p[0] <= 32'h0; m_p[1] <= 32'h0;
            m_halt <= 1'b0; m_bc <= 0; m_mc <= 0;
        end else if (!m_halt) begin
            if (m_bcond() != 0) m_bc <= m_bc + 1;
            if (m_mis() != 0) begin
                m_mc <= m_mc + 1; m_pc <= m_cnp(); m_v[0] <= 1'b0; m_v[1] <= 1'b0;
            end else if (fr_if.halt_req) m_halt <= 1'b1;
            else if (fr_if.stall) m_v[1] <= 1'b0;
            else begin
                m_v[1] <= m_v[0]; m_p[1] <= m_p[0];
                m_v[0] <= 1'b1; m_p[0] <= fr_if.pred_next_pc; m_pc <= fr_if.pred_next_pc;
            end
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_en) begin
            chk("pc", fr_if.pc, m_pc);
            chk("bcond", 32'(fr_if.bcond), m_bcond());
            chk("ex_correct_next_pc", fr_if.ex_correct_next_pc, m_cnp());
            chk("flush_if_id", 32'(fr_if.flush_if_id), m_mis());
            chk("flush_id_ex", 32'(fr_if.flush_id_ex), m_mis());
            chk("halted", 32'(fr_if.halted), 32'(m_halt));
            chk("branch_count", 32'(fr_if.branch_count), sat(m_bc));
            chk("mispredict_count", 32'(fr_if.mispredict_count), sat(m_mc));
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] pred);
        fr_if.pred_next_pc = pred;
        tick();
    endtask

    task automatic set_ex(input logic v, input logic c, input logic t, input logic [31:0] epc, input logic [31:0] tgt);
        fr_if.ex_valid = v; fr_if.ex_is_ctrl = c; fr_if.ex_taken = t; fr_if.ex_pc = epc; fr_if.ex_target = tgt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_ex(0, 0, 0, 0, 0);
        fr_if.stall = 1'b0; fr_if.halt_req = 1'b0; fr_if.pred_next_pc = 32'h0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        set_ex(0, 0, 0, 0, 0);
        fr_if.stall = 1'b0; fr_if.halt_req = 1'b0; fr_if.pred_next_pc = 32'h0;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("rst_pc", fr_if.pc, 32'h0);
        chk("rst_halted", 32'(fr_if.halted), 32'h0);
        chk("rst_branch_count", 32'(fr_if.branch_count), 32'h0);
        chk("rst_mispredict_count", 32'(fr_if.mispredict_count), 32'h0);

        // Sequential walk, EX retiring the non-control instruction fetched two cycles earlier.
        for (int i = 0; i < 6; i++) begin
            set_ex(i >= 2, 0, 0, 32'(4 * (i - 2)), 32'h0);
            fr_if.pred_next_pc = 32'(4 * i + 4);
            #1 chk("walk_flush", 32'(fr_if.flush_if_id), 32'h0);
            chk("walk_bcond", 32'(fr_if.bcond), 32'h0);
            tick();
            chk("walk_pc", fr_if.pc, 32'(4 * i + 4));
        end

        // Branch at 0x10 predicted 0x14, resolved taken to 0x40.
        set_ex(1, 1, 1, 32'h10, 32'h40);
        fr_if.pred_next_pc = 32'h1C;
        #1 chk("mp_bcond", 32'(fr_if.bcond), 32'h3);
        chk("mp_flush_if_id", 32'(fr_if.flush_if_id), 32'h1);
        chk("mp_flush_id_ex", 32'(fr_if.flush_id_ex), 32'h1);
        chk("mp_cnp", fr_if.ex_correct_next_pc, 32'h40);
        tick();
        chk("mp_pc", fr_if.pc, 32'h40);
        chk("mp_mispredict_count", 32'(fr_if.mispredict_count), 32'h1);
        chk("mp_branch_count", 32'(fr_if.branch_count), 32'h1);
        set_ex(0, 0, 0, 0, 0);
        step(32'h44);
        chk("post_redirect_pc", fr_if.pc, 32'h44);

        // Same branch predicted taken to 0x40 correctly.
        do_reset();
        for (int i = 1; i <= 4; i++) step(32'(4 * i));
        step(32'h40);
        set_ex(1, 0, 0, 32'hC, 32'h0);
        step(32'h44);
        set_ex(1, 1, 1, 32'h10, 32'h40);
        #1 chk("ok_bcond", 32'(fr_if.bcond), 32'h3);
        chk("ok_flush", 32'(fr_if.flush_if_id), 32'h0);
        step(32'h48);
        chk("ok_pc", fr_if.pc, 32'h48);
        chk("ok_branch_count", 32'(fr_if.branch_count), 32'h1);
        chk("ok_mispredict_count", 32'(fr_if.mispredict_count), 32'h0);

        // Two-cycle stall at 0xC; the bubbled ID/EX slot must not flag a redirect.
        do_reset();
        set_ex(0, 0, 0, 0, 0);
        step(32'h4); step(32'h8); step(32'hC);
        fr_if.stall = 1'b1;
        set_ex(1, 0, 0, 32'h4, 32'h0);
        fr_if.pred_next_pc = 32'h10;
        #1 chk("stall_flush", 32'(fr_if.flush_if_id), 32'h0);
        tick();
        chk("stall_pc1", fr_if.pc, 32'hC);
        set_ex(1, 0, 0, 32'h200, 32'h0);
        #1 chk("bubble_noflush", 32'(fr_if.flush_id_ex), 32'h0);
        chk("bubble_bcond", 32'(fr_if.bcond), 32'h0);
        tick();
        chk("stall_pc2", fr_if.pc, 32'hC);
        fr_if.stall = 1'b0;
        set_ex(0, 0, 0, 0, 0);
        tick();
        chk("unstall_pc", fr_if.pc, 32'h10);
        set_ex(1, 0, 0, 32'h8, 32'h0);
        #1 chk("unstall_flush", 32'(fr_if.flush_if_id), 32'h0);
        step(32'h14);

        // Mispredict, stall and halt together: redirect first, halt on the following edge.
        set_ex(1, 1, 1, 32'hC, 32'h80);
        fr_if.stall = 1'b1; fr_if.halt_req = 1'b1; fr_if.pred_next_pc = 32'h18;
        #1 chk("combo_flush", 32'(fr_if.flush_if_id), 32'h1);
        tick();
        chk("combo_pc", fr_if.pc, 32'h80);
        chk("combo_not_halted", 32'(fr_if.halted), 32'h0);
        set_ex(0, 0, 0, 0, 0);
        fr_if.stall = 1'b0;
        tick();
        chk("halted", 32'(fr_if.halted), 32'h1);
        fr_if.halt_req = 1'b0; fr_if.pred_next_pc = 32'h99;
        set_ex(1, 1, 0, 32'h80, 32'h0);
        #1 chk("halted_bcond", 32'(fr_if.bcond), 32'h0);
        chk("halted_flush", 32'(fr_if.flush_id_ex), 32'h0);
        tick(); tick();
        chk("halted_pc", fr_if.pc, 32'h80);
        chk("halted_branch_count", 32'(fr_if.branch_count), 32'h1);
        chk("halted_mispredict_count", 32'(fr_if.mispredict_count), 32'h1);
        set_ex(1, 0, 0, 32'hFFFF_FFFC, 32'h0);
        #1 chk("cnp_wrap", fr_if.ex_correct_next_pc, 32'h0);

        // Repeated forced mispredicts drive both counters into saturation.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            set_ex(0, 0, 0, 0, 0);
            step(m_pc + 32'd4);
            step(m_pc + 32'd4);
            set_ex(1, 1, 1, 32'h0, 32'h300);
            tick();
            if (k == 14) chk("mp_count_reach_max", 32'(fr_if.mispredict_count), 32'(SAT));
        end
        chk("mp_count_saturated", 32'(fr_if.mispredict_count), 32'(SAT));
        chk("br_count_saturated", 32'(fr_if.branch_count), 32'(SAT));
        chk("pre_reset_pc", fr_if.pc, 32'h300);

        // Asynchronous reset between clock edges.
        set_ex(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk("async_pc", fr_if.pc, 32'h0);
        chk("async_mispredict_count", 32'(fr_if.mispredict_count), 32'h0);
        chk("async_branch_count", 32'(fr_if.branch_count), 32'h0);
        tick();
        rst_n = 1'b1;
        step(32'h4);
        chk("post_reset_pc", fr_if.pc, 32'h4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
